// File: rtl/mul_req_scheduler_if.sv
// Requester-side operand streams and result stream of the shared multiplier scheduler.
interface mul_req_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned BIT_LEN = 17,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*BIT_LEN-1:0] req_a;
  logic [NUM_REQ*BIT_LEN-1:0] req_b;
  logic                       res_valid;
  logic                       res_ready;
  logic [BIT_LEN-1:0]         res_data;
  logic [ID_W-1:0]            res_id;
  logic                       res_last;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_last
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, res_last
  );
endinterface

// File: rtl/mul_req_scheduler.sv
// Round-robin scheduler sharing one multi-word multiplier between NUM_REQ requesters:
// serial operand load, fixed-latency wait, serial product drain tagged with the owner ID.
module mul_req_scheduler #(
  parameter int unsigned NUM_ELEMENTS = 17,
  parameter int unsigned BIT_LEN      = 17,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MUL_LATENCY  = 2,
  parameter int unsigned ID_W         = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  mul_req_scheduler_if.slave                  bus,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0]     mul_a,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0]     mul_b,
  input  logic [2*NUM_ELEMENTS*BIT_LEN-1:0]   mul_m,
  output logic                                busy
);
  localparam int unsigned OP_W   = NUM_ELEMENTS * BIT_LEN;
  localparam int unsigned PROD_W = 2 * OP_W;
  localparam int unsigned LOAD_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam int unsigned OUT_W  = $clog2(2 * NUM_ELEMENTS);
  localparam int unsigned LAT_W  = $clog2(MUL_LATENCY + 1);

  localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(NUM_ELEMENTS - 1);
  localparam logic [OUT_W-1:0]  OUT_LAST  = OUT_W'(2 * NUM_ELEMENTS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} state_t;

  state_t              state;
  logic [ID_W-1:0]     grant;
  logic [ID_W-1:0]     last_grant;
  logic [LOAD_W-1:0]   load_cnt;
  logic [LAT_W-1:0]    lat_cnt;
  logic [OUT_W-1:0]    out_cnt;
  logic [PROD_W-1:0]   res_buf;

  logic [ID_W-1:0]     arb_c;
  logic [ID_W-1:0]     cand_c;
  logic                arb_hit_c;
  logic [BIT_LEN-1:0]  sel_a_c;
  logic [BIT_LEN-1:0]  sel_b_c;
  logic                load_xfer_c;

  // Round-robin pick: scan from farthest to nearest so the nearest valid after last_grant wins.
  always_comb begin : arbiter
    arb_c     = '0;
    cand_c    = '0;
    arb_hit_c = 1'b0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      cand_c = ID_W'((int'(last_grant) + k) % int'(NUM_REQ));
      if (bus.req_valid[cand_c]) begin
        arb_c     = cand_c;
        arb_hit_c = 1'b1;
      end
    end
  end

  always_comb begin : operand_mux
    sel_a_c = '0;
    sel_b_c = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (grant == ID_W'(r)) begin
        sel_a_c = bus.req_a[r*BIT_LEN +: BIT_LEN];
        sel_b_c = bus.req_b[r*BIT_LEN +: BIT_LEN];
      end
    end
  end

  assign load_xfer_c = (state == LOAD) && bus.req_valid[grant] && bus.req_ready[grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= ID_W'(NUM_REQ - 1);
      load_cnt      <= '0;
      lat_cnt       <= '0;
      out_cnt       <= '0;
      res_buf       <= '0;
      mul_a         <= '0;
      mul_b         <= '0;
      busy          <= 1'b0;
      bus.req_ready <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_id    <= '0;
      bus.res_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_hit_c) begin
            grant         <= arb_c;
            last_grant    <= arb_c;
            load_cnt      <= '0;
            bus.req_ready <= NUM_REQ'(1) << arb_c;
            busy          <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          if (load_xfer_c) begin
            for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
              if (load_cnt == LOAD_W'(i)) begin
                mul_a[i*BIT_LEN +: BIT_LEN] <= sel_a_c;
                mul_b[i*BIT_LEN +: BIT_LEN] <= sel_b_c;
              end
            end
            if (load_cnt == LOAD_LAST) begin
              bus.req_ready <= '0;
              lat_cnt       <= LAT_W'(MUL_LATENCY);
              state         <= WAIT;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        WAIT: begin
          // Operands have been stable for MUL_LATENCY edges when lat_cnt reaches 1.
          if (lat_cnt == LAT_W'(1)) begin
            res_buf       <= mul_m;
            out_cnt       <= '0;
            bus.res_valid <= 1'b1;
            bus.res_data  <= mul_m[BIT_LEN-1:0];
            bus.res_id    <= grant;
            bus.res_last  <= 1'b0;
            state         <= DRAIN;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        DRAIN: begin
          if (bus.res_ready) begin
            if (bus.res_last) begin
              bus.res_valid <= 1'b0;
              bus.res_last  <= 1'b0;
              busy          <= 1'b0;
              state         <= IDLE;
            end else begin
              // Buffer shifts down so the next word is always in the second slot.
              out_cnt      <= out_cnt + 1'b1;
              res_buf      <= res_buf >> BIT_LEN;
              bus.res_data <= res_buf[2*BIT_LEN-1:BIT_LEN];
              bus.res_last <= ((out_cnt + 1'b1) == OUT_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_req_scheduler.sv
// Directed bench for mul_req_scheduler: latency-2 instance for the main scenarios and a
// latency-5 instance whose multiplier stub presents the product for exactly one cycle.
module tb_mul_req_scheduler;
  localparam int unsigned NE   = 17;
  localparam int unsigned BL   = 17;
  localparam int unsigned NR   = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned LAT  = 2;
  localparam int unsigned LAT5 = 5;
  localparam int unsigned OPW  = NE * BL;
  localparam int unsigned PW   = 2 * OPW;
  localparam int unsigned NW   = 2 * NE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mul_req_scheduler_if #(.NUM_REQ(NR), .BIT_LEN(BL), .ID_W(IDW)) bus ();
  mul_req_scheduler_if #(.NUM_REQ(NR), .BIT_LEN(BL), .ID_W(IDW)) bus5 ();

  logic [OPW-1:0] mul_a, mul_b, mul5_a, mul5_b;
  logic [PW-1:0]  mul_m, mul5_m;
  logic           busy, busy5;

  mul_req_scheduler #(.NUM_ELEMENTS(NE), .BIT_LEN(BL), .NUM_REQ(NR), .MUL_LATENCY(LAT), .ID_W(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m), .busy(busy));

  mul_req_scheduler #(.NUM_ELEMENTS(NE), .BIT_LEN(BL), .NUM_REQ(NR), .MUL_LATENCY(LAT5), .ID_W(IDW)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5), .mul_a(mul5_a), .mul_b(mul5_b), .mul_m(mul5_m), .busy(busy5));

  function automatic logic [PW-1:0] ref_mul(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    return {{OPW{1'b0}}, a} * {{OPW{1'b0}}, b};
  endfunction

  function automatic logic [OPW-1:0] rand_op();
    logic [OPW-1:0] v;
    for (int i = 0; i < int'(NE); i++) v[i*BL +: BL] = BL'($urandom);
    return v;
  endfunction

  // Multiplier stubs: product shown only in the one cycle the scheduler must sample, else all ones.
  int unsigned m_cnt, m5_cnt;
  logic [LAT-1:0]  m_dl;
  logic [LAT5-1:0] m5_dl;
  logic m_last, m5_last;
  assign m_last  = (|(bus.req_valid & bus.req_ready)) && (m_cnt == NE - 1);
  assign m5_last = (|(bus5.req_valid & bus5.req_ready)) && (m5_cnt == NE - 1);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_dl <= '0; m5_cnt <= 0; m5_dl <= '0;
    end else begin
      if (|(bus.req_valid & bus.req_ready))   m_cnt  <= m_last  ? 0 : m_cnt + 1;
      if (|(bus5.req_valid & bus5.req_ready)) m5_cnt <= m5_last ? 0 : m5_cnt + 1;
      m_dl  <= {m_dl[LAT-2:0], m_last};
      m5_dl <= {m5_dl[LAT5-2:0], m5_last};
    end
  end
  assign mul_m  = m_dl[LAT-1]   ? ref_mul(mul_a, mul_b)   : {PW{1'b1}};
  assign mul5_m = m5_dl[LAT5-1] ? ref_mul(mul5_a, mul5_b) : {PW{1'b1}};

  // Requester drivers for the latency-2 instance: one word queue per requester.
  logic [BL-1:0] qa[NR][$];
  logic [BL-1:0] qb[NR][$];
  bit            hold[NR];

  initial forever begin
    @(negedge clk);
    for (int r = 0; r < int'(NR); r++) begin
      if (!hold[r] && qa[r].size() > 0) begin
        bus.req_valid[r] = 1'b1;
        bus.req_a[r*BL +: BL] = qa[r][0];
        bus.req_b[r*BL +: BL] = qb[r][0];
      end else begin
        bus.req_valid[r] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    for (int r = 0; r < int'(NR); r++) begin
      if (rst_n && bus.req_valid[r] && bus.req_ready[r] && qa[r].size() > 0) begin
        void'(qa[r].pop_front());
        void'(qb[r].pop_front());
      end
    end
  end

  // Result sinks and ready-exclusivity monitor.
  logic [BL-1:0]  rd_q[$], r5d_q[$];
  logic [IDW-1:0] rid_q[$], r5id_q[$];
  bit             rl_q[$], r5l_q[$];
  int             multi_rdy = 0;

  always @(posedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      rd_q.push_back(bus.res_data); rid_q.push_back(bus.res_id); rl_q.push_back(bus.res_last);
    end
    if (rst_n && bus5.res_valid && bus5.res_ready) begin
      r5d_q.push_back(bus5.res_data); r5id_q.push_back(bus5.res_id); r5l_q.push_back(bus5.res_last);
    end
    if ($countones(bus.req_ready) > 1) multi_rdy <= multi_rdy + 1;
  end

  task automatic push_op(input int r, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    for (int i = 0; i < int'(NE); i++) begin
      qa[r].push_back(a[i*BL +: BL]);
      qb[r].push_back(b[i*BL +: BL]);
    end
  endtask

  // Collects one full result (NW words) from the chosen sink, bounded wait.
  task automatic get_result(input bit sel5, output int id, output logic [PW-1:0] p,
                            output bit got, output bit last_ok, output bit id_ok);
    logic [BL-1:0] d;
    logic [IDW-1:0] i;
    bit l;
    got = 1'b0; last_ok = 1'b1; id_ok = 1'b1; p = '0; id = -1;
    for (int c = 0; c < 400; c++) begin
      if ((sel5 ? r5d_q.size() : rd_q.size()) >= NW) break;
      @(negedge clk);
    end
    if ((sel5 ? r5d_q.size() : rd_q.size()) >= NW) begin
      got = 1'b1;
      for (int k = 0; k < int'(NW); k++) begin
        if (sel5) begin d = r5d_q.pop_front(); i = r5id_q.pop_front(); l = r5l_q.pop_front(); end
        else      begin d = rd_q.pop_front();  i = rid_q.pop_front();  l = rl_q.pop_front();  end
        p[k*BL +: BL] = d;
        if (k == 0) id = int'(i);
        else if (int'(i) != id) id_ok = 1'b0;
        if (l != (k == int'(NW) - 1)) last_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.res_ready = 1'b1;
    bus5.res_ready = 1'b1; bus5.req_valid = '0; bus5.req_a = '0; bus5.req_b = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    checks++; if (bus.res_data !== 17'd0 || bus.res_id !== 2'd0 || bus.res_last !== 1'b0) begin
      errors++; $display("FAIL reset_res_fields: got data %h id %0d last %b expected 0 0 0", bus.res_data, bus.res_id, bus.res_last); end
    checks++; if (mul_a !== '0 || mul_b !== '0) begin errors++; $display("FAIL reset_mul_ops: got a %h b %h expected 0", mul_a, mul_b); end
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL reset_busy5: got %b expected 0", busy5); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.req_ready !== 4'b0) begin
      errors++; $display("FAIL reset_release_idle: got busy %b ready %b expected 0 0000", busy, bus.req_ready); end
  endtask

  task automatic test_single();
    logic [PW-1:0] p;
    int id, rdy_cnt, t_rdy, t_res;
    bit got, last_ok, id_ok, seen, done;
    rdy_cnt = 0; t_rdy = -1; t_res = -1; seen = 1'b0; done = 1'b0;
    push_op(2, OPW'(3), OPW'(5));
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.req_ready[2]) begin rdy_cnt++; if (t_rdy < 0) t_rdy = c; end
      if (bus.res_valid && t_res < 0) t_res = c;
      if (busy) seen = 1'b1;
      else if (seen) begin done = 1'b1; break; end
    end
    checks++; if (!done) begin errors++; $display("FAIL single_done: busy never returned low (timeout)"); end
    checks++; if (rd_q.size() != NW) begin errors++; $display("FAIL single_busy_span: got %0d words when busy fell expected %0d", rd_q.size(), NW); end
    checks++; if (rdy_cnt != 17) begin errors++; $display("FAIL single_ready_cycles: got %0d expected 17", rdy_cnt); end
    checks++; if (t_res - t_rdy != 19) begin errors++; $display("FAIL single_load_to_result: got %0d expected 19", t_res - t_rdy); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_res_valid_after: got %b expected 0", bus.res_valid); end
    get_result(1'b0, id, p, got, last_ok, id_ok);
    checks++; if (!got || p !== PW'(15)) begin errors++; $display("FAIL single_product: got %h expected %h", p, PW'(15)); end
    checks++; if (id != 2 || !id_ok) begin errors++; $display("FAIL single_id: got %0d (consistent %b) expected 2", id, id_ok); end
    checks++; if (!last_ok) begin errors++; $display("FAIL single_last: got misplaced res_last expected only on word 34"); end
  endtask

  task automatic test_backpressure();
    logic [OPW-1:0] a, b;
    logic [PW-1:0] p;
    logic [BL-1:0] pd;
    bit pv, pr, pl, seen, got, last_ok, id_ok;
    int id, stall_cnt, stall_bad;
    a = rand_op(); b = rand_op();
    pv = 1'b0; pr = 1'b1; pd = '0; pl = 1'b0; seen = 1'b0; stall_cnt = 0; stall_bad = 0;
    push_op(3, a, b);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (pv && !pr && bus.res_valid) begin
        stall_cnt++;
        if (bus.res_data !== pd || bus.res_last !== pl) stall_bad++;
      end
      pv = bus.res_valid; pd = bus.res_data; pl = bus.res_last;
      pr = (c % 4 == 0) || (c % 4 == 3);
      bus.res_ready = pr;
      if (busy) seen = 1'b1;
      else if (seen) break;
    end
    bus.res_ready = 1'b1;
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changed words expected 0", stall_bad); end
    checks++; if (stall_cnt == 0) begin errors++; $display("FAIL bp_stalls_seen: got 0 stalled cycles expected >0"); end
    get_result(1'b0, id, p, got, last_ok, id_ok);
    checks++; if (!got || p !== ref_mul(a, b)) begin errors++; $display("FAIL bp_product: got %h expected %h", p, ref_mul(a, b)); end
    checks++; if (id != 3 || !id_ok || !last_ok) begin errors++; $display("FAIL bp_id_last: got id %0d consistent %b last_ok %b expected 3 1 1", id, id_ok, last_ok); end
  endtask

  task automatic test_back_to_back();
    logic [OPW-1:0] oa[5], ob[5];
    logic [PW-1:0] p;
    int exp_id[5];
    int id;
    bit got, last_ok, id_ok;
    exp_id = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin oa[k] = rand_op(); ob[k] = rand_op(); end
    for (int k = 0; k < 5; k++) push_op(exp_id[k], oa[k], ob[k]);
    for (int k = 0; k < 5; k++) begin
      get_result(1'b0, id, p, got, last_ok, id_ok);
      checks++; if (!got || id != exp_id[k] || !id_ok) begin
        errors++; $display("FAIL b2b_id op%0d: got %0d (got %b) expected %0d", k, id, got, exp_id[k]); end
      checks++; if (p !== ref_mul(oa[k], ob[k]) || !last_ok) begin
        errors++; $display("FAIL b2b_product op%0d: got %h expected %h", k, p, ref_mul(oa[k], ob[k])); end
    end
    checks++; if (multi_rdy != 0) begin errors++; $display("FAIL b2b_ready_onehot: got %0d multi-ready cycles expected 0", multi_rdy); end
  endtask

  task automatic test_valid_drop();
    logic [OPW-1:0] a, b;
    logic [PW-1:0] p;
    int id, t_rdy, t_res, hold_left;
    bit held, seen, done, got, last_ok, id_ok;
    a = rand_op(); b = rand_op();
    t_rdy = -1; t_res = -1; hold_left = 0; held = 1'b0; seen = 1'b0; done = 1'b0;
    push_op(1, a, b);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (bus.req_ready[1] && t_rdy < 0) t_rdy = c;
      if (bus.res_valid && t_res < 0) t_res = c;
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) hold[1] = 1'b0;
      end else if (!held && qa[1].size() == NE - 8) begin
        hold[1] = 1'b1; held = 1'b1; hold_left = 3;
      end
      if (busy) seen = 1'b1;
      else if (seen) begin done = 1'b1; break; end
    end
    hold[1] = 1'b0;
    checks++; if (!done || !held) begin errors++; $display("FAIL drop_done: got done %b held %b expected 1 1", done, held); end
    checks++; if (t_res - t_rdy != 22) begin errors++; $display("FAIL drop_slip: got %0d expected 22", t_res - t_rdy); end
    get_result(1'b0, id, p, got, last_ok, id_ok);
    checks++; if (!got || p !== ref_mul(a, b) || id != 1) begin
      errors++; $display("FAIL drop_product: got id %0d %h expected id 1 %h", id, p, ref_mul(a, b)); end
  endtask

  task automatic test_reset_drain();
    logic [OPW-1:0] a0, b0, a1, b1;
    logic [PW-1:0] p;
    int id;
    bit got, last_ok, id_ok;
    push_op(2, rand_op(), rand_op());
    for (int c = 0; c < 300 && rd_q.size() < 10; c++) @(negedge clk);
    checks++; if (rd_q.size() != 10 || !bus.res_valid) begin
      errors++; $display("FAIL rstd_reach: got %0d words valid %b expected 10 1", rd_q.size(), bus.res_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstd_async: got valid %b busy %b expected 0 0", bus.res_valid, busy); end
    repeat (2) @(negedge clk);
    rd_q.delete(); rid_q.delete(); rl_q.delete();
    for (int r = 0; r < int'(NR); r++) begin qa[r].delete(); qb[r].delete(); end
    a0 = rand_op(); b0 = rand_op(); a1 = rand_op(); b1 = rand_op();
    push_op(1, a1, b1);
    push_op(0, a0, b0);
    rst_n = 1'b1;
    get_result(1'b0, id, p, got, last_ok, id_ok);
    checks++; if (!got || id != 0 || p !== ref_mul(a0, b0) || !last_ok) begin
      errors++; $display("FAIL rstd_first: got id %0d %h expected id 0 %h", id, p, ref_mul(a0, b0)); end
    get_result(1'b0, id, p, got, last_ok, id_ok);
    checks++; if (!got || id != 1 || p !== ref_mul(a1, b1)) begin
      errors++; $display("FAIL rstd_second: got id %0d %h expected id 1 %h", id, p, ref_mul(a1, b1)); end
  endtask

  task automatic test_latency5();
    logic [OPW-1:0] a, b;
    logic [PW-1:0] p;
    int id, idx;
    bit xfer, got, last_ok, id_ok;
    a = rand_op(); b = rand_op(); idx = 0;
    for (int c = 0; c < 300 && idx < int'(NE); c++) begin
      @(negedge clk);
      bus5.req_valid = 4'b0010;
      bus5.req_a[BL +: BL] = a[idx*BL +: BL];
      bus5.req_b[BL +: BL] = b[idx*BL +: BL];
      xfer = bus5.req_ready[1];
      @(posedge clk);
      if (xfer) idx++;
    end
    @(negedge clk);
    bus5.req_valid = '0;
    checks++; if (idx != int'(NE)) begin errors++; $display("FAIL lat5_load: got %0d words expected %0d", idx, NE); end
    get_result(1'b1, id, p, got, last_ok, id_ok);
    checks++; if (!got || p !== ref_mul(a, b)) begin errors++; $display("FAIL lat5_capture: got %h expected %h", p, ref_mul(a, b)); end
    checks++; if (id != 1 || !id_ok || !last_ok) begin errors++; $display("FAIL lat5_id_last: got id %0d last_ok %b expected 1 1", id, last_ok); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_valid_drop();
    test_reset_drain();
    test_latency5();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
